// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
//   Shared definitions for the boot-time program loader: the frame sync byte,
//   the loader FSM state encoding and the instruction-width derivation.
//   No ports (package).
package prog_loader_pkg;

  // First byte of every frame; anything else seen while idle is line noise.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN_H = 3'd1,
    ST_LEN_L = 3'd2,
    ST_DATA  = 3'd3,
    ST_CHK   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  // Instruction word width in bits for a given number of bytes per word.
  function automatic int calc_instr_w(input int instr_bytes);
    return 8 * instr_bytes;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if
//   Bundles the loader's byte-stream input, reload pulse, instruction-memory
//   write port and status outputs.
//   master : byte source / system side (drives rx_data, rx_valid, reload)
//   slave  : the loader (drives rx_ready, imem_*, cpu_rst, load_done, load_err)
//   Parameters INSTR_BYTES and ADDR_W must match those of the loader.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int INSTR_BYTES = 2,
  parameter int ADDR_W      = 8
);
  localparam int INSTR_W = calc_instr_w(INSTR_BYTES);

  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               reload;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               cpu_rst;
  logic               load_done;
  logic               load_err;

  modport master (
    output rx_data, rx_valid, reload,
    input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst, load_done, load_err
  );

  modport slave (
    input  rx_data, rx_valid, reload,
    output rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst, load_done, load_err
  );

endinterface

// File: rtl/prog_word_asm.sv
// prog_word_asm
//   Assembles incoming bytes, MSB first, into instruction words.
//   Ports:
//     clk          in   system clock
//     rst          in   asynchronous active-high reset
//     i_clear      in   restart assembly at byte 0 (has priority over i_shift_en)
//     i_shift_en   in   i_byte is a data byte to be taken this cycle
//     i_byte       in   data byte
//     o_word_ready out  this cycle's byte completes a word (combinational pulse)
//     o_word       out  the word as it stands including this cycle's byte;
//                       valid as a full word while o_word_ready is high
module prog_word_asm
  import prog_loader_pkg::*;
#(
  parameter int INSTR_BYTES = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_clear,
  input  logic                                 i_shift_en,
  input  logic [7:0]                           i_byte,
  output logic                                 o_word_ready,
  output logic [calc_instr_w(INSTR_BYTES)-1:0] o_word
);
  localparam int INSTR_W = calc_instr_w(INSTR_BYTES);
  localparam int BC_W    = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(INSTR_BYTES - 1);

  logic [BC_W-1:0] r_byte_cnt;
  logic            w_last_byte;

  assign w_last_byte  = (r_byte_cnt == LAST_BYTE);
  assign o_word_ready = i_shift_en & ~i_clear & w_last_byte;

  // Byte position within the current word, counting modulo INSTR_BYTES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt <= '0;
    end else if (i_clear) begin
      r_byte_cnt <= '0;
    end else if (i_shift_en) begin
      r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + BC_W'(1);
    end
  end

  generate
    if (INSTR_BYTES == 1) begin : g_single
      assign o_word = i_byte;
    end else begin : g_multi
      // Holds the earlier bytes of the word; the current byte is appended
      // combinationally so the completed word is available in the same
      // cycle as its last byte. Older bytes simply shift out, so no clear
      // is needed at a word boundary.
      logic [INSTR_W-9:0] r_shift;

      assign o_word = {r_shift, i_byte};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_shift <= '0;
        end else if (i_clear) begin
          r_shift <= '0;
        end else if (i_shift_en) begin
          r_shift <= o_word[INSTR_W-9:0];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/prog_loader.sv
// prog_loader
//   Boot-time program loader. Receives a framed byte stream
//     0xA5, LEN_HI, LEN_LO, N words of data bytes (MSB first), CHK
//   writes word k to instruction-memory address k, and releases the core
//   reset only once the whole image is written and the XOR checksum of the
//   data bytes matches CHK.
//   Ports:
//     clk     in   system clock, all state on the rising edge
//     rst     in   asynchronous active-high reset
//     io_bus  slave side of prog_loader_if:
//       rx_data/rx_valid/rx_ready  byte stream, accepted on valid & ready
//       reload                     1-cycle abort/restart pulse
//       imem_we/imem_addr/imem_wdata  instruction-memory write port
//       cpu_rst                    core reset (1 = held)
//       load_done / load_err       final status of the last frame
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int INSTR_BYTES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.slave io_bus
);
  localparam int INSTR_W = calc_instr_w(INSTR_BYTES);
  // Largest legal image, in words. 17 bits so 2**16 still fits.
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  state_t             r_state;
  logic               r_rx_ready;
  logic               r_cpu_rst;
  logic               r_load_done;
  logic               r_load_err;
  logic               r_imem_we;
  logic [ADDR_W-1:0]  r_imem_addr;
  logic [INSTR_W-1:0] r_imem_wdata;
  logic [7:0]         r_len_hi;
  logic [15:0]        r_len;
  logic [15:0]        r_word_cnt;
  logic [7:0]         r_xor;

  logic               w_accept;
  logic               w_shift_en;
  logic               w_asm_clear;
  logic               w_word_ready;
  logic [INSTR_W-1:0] w_word;
  logic [15:0]        w_len_new;
  logic               w_len_bad;
  logic               w_last_word;

  assign w_accept    = io_bus.rx_valid & r_rx_ready;
  // reload wins over a simultaneous byte, so that byte must not reach the
  // word assembler either.
  assign w_shift_en  = w_accept & ~io_bus.reload & (r_state == ST_DATA);
  assign w_asm_clear = io_bus.reload | (r_state != ST_DATA);
  assign w_len_new   = {r_len_hi, io_bus.rx_data};
  assign w_len_bad   = (w_len_new == 16'd0) || ({1'b0, w_len_new} > MAX_WORDS);
  assign w_last_word = (({1'b0, r_word_cnt} + 17'd1) == {1'b0, r_len});

  prog_word_asm #(
    .INSTR_BYTES (INSTR_BYTES)
  ) u_word_asm (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_asm_clear),
    .i_shift_en   (w_shift_en),
    .i_byte       (io_bus.rx_data),
    .o_word_ready (w_word_ready),
    .o_word       (w_word)
  );

  // Single FSM with all outputs registered. The memory write is launched on
  // the same edge that accepts a word's last byte, so imem_we is high in the
  // following cycle; for the last word that cycle ends no later than the
  // edge that accepts CHK and releases the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rx_ready   <= 1'b1;
      r_cpu_rst    <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_len_hi     <= '0;
      r_len        <= '0;
      r_word_cnt   <= '0;
      r_xor        <= '0;
    end else begin
      r_imem_we <= 1'b0;
      if (io_bus.reload) begin
        r_state     <= ST_IDLE;
        r_rx_ready  <= 1'b1;
        r_cpu_rst   <= 1'b1;
        r_load_done <= 1'b0;
        r_load_err  <= 1'b0;
        r_len_hi    <= '0;
        r_len       <= '0;
        r_word_cnt  <= '0;
        r_xor       <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept && (io_bus.rx_data == SYNC_BYTE)) begin
              r_state <= ST_LEN_H;
            end
          end
          ST_LEN_H: begin
            if (w_accept) begin
              r_len_hi <= io_bus.rx_data;
              r_state  <= ST_LEN_L;
            end
          end
          ST_LEN_L: begin
            if (w_accept) begin
              r_len      <= w_len_new;
              r_word_cnt <= '0;
              r_xor      <= '0;
              if (w_len_bad) begin
                r_state    <= ST_ERR;
                r_rx_ready <= 1'b0;
                r_load_err <= 1'b1;
              end else begin
                r_state <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (w_accept) begin
              r_xor <= r_xor ^ io_bus.rx_data;
              if (w_word_ready) begin
                r_imem_we    <= 1'b1;
                r_imem_addr  <= r_word_cnt[ADDR_W-1:0];
                r_imem_wdata <= w_word;
                // The counter is left at the last index rather than stepping
                // past 2**ADDR_W-1, so it never wraps.
                if (w_last_word) begin
                  r_state <= ST_CHK;
                end else begin
                  r_word_cnt <= r_word_cnt + 16'd1;
                end
              end
            end
          end
          ST_CHK: begin
            if (w_accept) begin
              r_rx_ready <= 1'b0;
              if (io_bus.rx_data == r_xor) begin
                r_state     <= ST_DONE;
                r_cpu_rst   <= 1'b0;
                r_load_done <= 1'b1;
              end else begin
                r_state    <= ST_ERR;
                r_load_err <= 1'b1;
              end
            end
          end
          default: begin
            // DONE and ERR hold until reload or rst.
          end
        endcase
      end
    end
  end

  assign io_bus.rx_ready   = r_rx_ready;
  assign io_bus.imem_we    = r_imem_we;
  assign io_bus.imem_addr  = r_imem_addr;
  assign io_bus.imem_wdata = r_imem_wdata;
  assign io_bus.cpu_rst    = r_cpu_rst;
  assign io_bus.load_done  = r_load_done;
  assign io_bus.load_err   = r_load_err;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
//   Self-checking bench for prog_loader. Frames are built from the framing
//   rules (sync, 16-bit length, MSB-first words, XOR checksum); the expected
//   memory writes go into a scoreboard queue that a separate monitor drains
//   whenever imem_we is seen, and the expected final status is derived from
//   the length bounds and the checksum.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int INSTR_BYTES = 2;
  localparam int ADDR_W      = 8;
  localparam int MAX_N       = 1 << ADDR_W;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  wr_t         sb_q[$];
  wr_t         mon_exp;
  logic [15:0] word_src[$];

  prog_loader_if #(.INSTR_BYTES(INSTR_BYTES), .ADDR_W(ADDR_W)) bus ();

  prog_loader #(
    .INSTR_BYTES (INSTR_BYTES),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write, and
  // must be seen while the loader has not yet declared the image done.
  always @(negedge clk) begin
    if (!rst && bus.imem_we === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%02h:%04h required=none",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        mon_exp = sb_q.pop_front();
        if (bus.imem_addr !== mon_exp.addr || bus.imem_wdata !== mon_exp.data ||
            bus.load_done !== 1'b0) begin
          failures++;
          $display("FAIL imem_write actual=%02h:%04h done=%0b required=%02h:%04h done=0",
                   bus.imem_addr, bus.imem_wdata, bus.load_done, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_ready);
    if (expect_ready) check("rx_ready_in_frame", 32'(bus.rx_ready), 32'd1);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  // reload pulse, optionally with a byte handshake in the same cycle (which
  // must be dropped); status must be back to "held, idle" right after.
  task automatic do_reload(input bit with_byte);
    bus.reload   = 1'b1;
    bus.rx_valid = with_byte;
    bus.rx_data  = SYNC_BYTE;
    @(posedge clk);
    #1;
    bus.reload   = 1'b0;
    bus.rx_valid = 1'b0;
    check("reload.cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("reload.load_done", 32'(bus.load_done), 32'd0);
    check("reload.load_err", 32'(bus.load_err), 32'd0);
    check("reload.rx_ready", 32'(bus.rx_ready), 32'd1);
  endtask

  // chk_force: -1 = correct checksum, -2 = random wrong checksum,
  // otherwise the literal checksum byte to send.
  task automatic do_frame(input string name, input int n, input int chk_force,
                          input int noise, input bit gaps);
    logic [7:0]  stream[$];
    logic [7:0]  x;
    logic [7:0]  nb;
    logic [7:0]  chk;
    logic [15:0] n16;
    logic [15:0] w;
    wr_t         e;
    bit          len_ok;
    bit          expect_done;

    x      = 8'h00;
    n16    = 16'(n);
    len_ok = (n >= 1) && (n <= MAX_N);
    for (int i = 0; i < noise; i++) begin
      do nb = 8'($urandom); while (nb == SYNC_BYTE);
      stream.push_back(nb);
    end
    stream.push_back(SYNC_BYTE);
    stream.push_back(n16[15:8]);
    stream.push_back(n16[7:0]);
    expect_done = 1'b0;
    if (len_ok) begin
      for (int k = 0; k < n; k++) begin
        w = (k < word_src.size()) ? word_src[k] : 16'($urandom);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
        x      = x ^ w[15:8] ^ w[7:0];
        e.addr = 8'(k);
        e.data = w;
        sb_q.push_back(e);
      end
      if (chk_force == -1)      chk = x;
      else if (chk_force == -2) chk = x ^ 8'($urandom_range(1, 255));
      else                      chk = 8'(chk_force);
      stream.push_back(chk);
      expect_done = (chk == x);
    end

    foreach (stream[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send_byte(stream[i], 1'b1);
    end

    check({name, ".load_done"}, 32'(bus.load_done), 32'(expect_done));
    check({name, ".load_err"}, 32'(bus.load_err), 32'(!expect_done));
    check({name, ".cpu_rst"}, 32'(bus.cpu_rst), 32'(!expect_done));
    check({name, ".rx_ready"}, 32'(bus.rx_ready), 32'd0);
    idle(2);
    check({name, ".writes_pending"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    $display("frame %s n=%0d noise=%0d gaps=%0b expect=%s", name, n, noise, gaps,
             expect_done ? "done" : "err");
  endtask

  initial begin
    int n;
    int r;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.reload   = 1'b0;
    rst          = 1'b1;

    // Reset values
    #12;
    check("rst.cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("rst.rx_ready", 32'(bus.rx_ready), 32'd1);
    check("rst.imem_we", 32'(bus.imem_we), 32'd0);
    check("rst.imem_addr", 32'(bus.imem_addr), 32'd0);
    check("rst.imem_wdata", 32'(bus.imem_wdata), 32'd0);
    check("rst.load_done", 32'(bus.load_done), 32'd0);
    check("rst.load_err", 32'(bus.load_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Good load, back-to-back
    word_src = '{16'h1234, 16'h5678, 16'h9ABC};
    do_frame("good", 3, -1, 0, 1'b0);

    // Bytes offered in DONE are ignored and change nothing
    send_byte(SYNC_BYTE, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    check("done_hold.load_done", 32'(bus.load_done), 32'd1);
    check("done_hold.cpu_rst", 32'(bus.cpu_rst), 32'd0);

    // Asynchronous reset mid-cycle while DONE
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("async_rst.rx_ready", 32'(bus.rx_ready), 32'd1);
    check("async_rst.imem_we", 32'(bus.imem_we), 32'd0);
    check("async_rst.load_done", 32'(bus.load_done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Noise before sync
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    do_frame("noise_then_good", 3, -1, 0, 1'b0);
    do_reload(1'b0);

    // Bad checksum
    do_frame("bad_chk", 3, 8'h00, 0, 1'b0);
    do_reload(1'b0);

    // Bad lengths
    do_frame("len0", 0, -1, 0, 1'b0);
    do_reload(1'b0);
    do_frame("len257", 257, -1, 0, 1'b0);
    do_reload(1'b0);

    // reload mid-DATA after one word, then a full good frame from address 0
    e_push(8'h00, 16'h1234);
    send_byte(SYNC_BYTE, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    do_reload(1'b0);
    idle(1);
    check("mid_reload.writes_pending", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    do_frame("after_reload", 3, -1, 0, 1'b0);
    do_reload(1'b0);

    // reload with a simultaneous 0xA5 handshake: that byte must be dropped
    do_reload(1'b1);
    do_frame("after_reload_byte", 3, -1, 0, 1'b0);
    do_reload(1'b0);

    // Largest image: final write at address 2**ADDR_W-1
    word_src.delete();
    do_frame("max_len", MAX_N, -1, 0, 1'b0);
    do_reload(1'b0);

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_N + 1, MAX_N + 100);
      else if (r == 1) n = MAX_N;
      else             n = $urandom_range(1, 8);
      do_frame("random", n, ($urandom_range(0, 3) == 0) ? -2 : -1,
               $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      do_reload(1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic e_push(input logic [7:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

endmodule
